// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: keeps the PC, issues one outstanding
// instruction-memory read at a time, buffers the returned word and presents
// it downstream over a valid/ready handshake. Execute-stage redirects take
// priority in every state and wrong-path responses are discarded.
module instr_fetch_unit #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction memory
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rvalid,
   input  logic [XLEN-1:0]   imem_rdata,
   // redirect from execute
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   // downstream instruction interface
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [XLEN-1:0]   instr,
   output logic [6:0]        opcode,
   output logic [XLEN-1:0]   instr_pc
);

   typedef enum logic [1:0] {
      ST_REQ,   // issue a request for pc
      ST_WAIT,  // one request outstanding, waiting for imem_rvalid
      ST_HOLD   // buffered instruction presented downstream
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic              drop_q;
   logic              instr_valid_q;
   logic [XLEN-1:0]   instr_q;
   logic [XLEN-1:0]   instr_pc_q;

   logic [XLEN-1:0]   redirect_target;
   logic              fire;

   // Redirect targets are forced onto a word boundary.
   assign redirect_target = redirect_pc & ~XLEN'(3);

   // A redirect in the same cycle blocks consumption of the presented word.
   assign fire = instr_valid_q & instr_ready & ~redirect_valid;

   assign imem_req    = rst_n & (state_q == ST_REQ) & ~redirect_valid;
   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign instr_pc    = instr_pc_q;

   // Next-state logic; a redirect always returns to (or stays in) REQ unless
   // a response is still outstanding and has not yet arrived.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_REQ: begin
            if (!redirect_valid) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               state_d = (redirect_valid || drop_q) ? ST_REQ : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect_valid || fire) state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled at the same edge.
      if (!rst_n) state_q <= ST_REQ;
      else        state_q <= state_d;
   end

   // PC, drop flag and instruction buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         drop_q        <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         if (redirect_valid) begin
            pc_q          <= redirect_target;
            instr_valid_q <= 1'b0;
         end
         unique case (state_q)
            ST_WAIT: begin
               if (imem_rvalid) begin
                  // The outstanding response has returned; nothing is left to discard.
                  drop_q <= 1'b0;
                  if (!drop_q && !redirect_valid) begin
                     instr_q       <= imem_rdata;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                     pc_q          <= pc_q + XLEN'(4);
                  end
               end else if (redirect_valid) begin
                  // Response to the old path is still in flight; discard it later.
                  drop_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (fire) instr_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level model
// (outstanding request / stale response / buffered instruction) and a
// latency-programmable instruction memory.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] instr_pc;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // driven inputs for the next cycle
   logic        drv_rst   = 1'b0;
   logic        drv_redir = 1'b0;
   logic [31:0] drv_rpc   = '0;
   logic        drv_ready = 1'b1;
   int          mem_lat   = 1;      // 0 = random 1..4
   bit          spur_en   = 1'b0;
   bit          chk_en    = 1'b0;

   // reference model
   logic [31:0] m_pc    = 32'h0;
   bit          m_busy  = 1'b0;     // a request is outstanding
   bit          m_stale = 1'b0;     // the outstanding response belongs to a dead path
   bit          m_have  = 1'b0;     // an instruction is buffered
   logic [31:0] m_instr = '0;
   logic [31:0] m_ipc   = '0;

   // memory response schedule
   int          due_q[$];
   logic [31:0] adr_q[$];

   // observation log
   int          req_cyc[$];
   logic [31:0] req_adr[$];
   int          first_valid = -1;
   logic [6:0]  first_op;
   logic [31:0] watch_pc = 32'hFFFF_FFFF;
   int          watch_hits = 0;
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr, obs_instr, obs_ipc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h0000_0013;
         32'h0000_0010: return 32'h00A0_0023;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step();
      bit          exp_req, resp;
      logic        rv;
      logic [31:0] rd;
      int          lat;
      @(negedge clk);
      rst_n          = drv_rst;
      redirect_valid = drv_redir;
      redirect_pc    = drv_rpc;
      instr_ready    = drv_ready;
      rv = 1'b0;
      rd = $urandom;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         rv = 1'b1;
         rd = mem_word(adr_q[0]);
         void'(due_q.pop_front());
         void'(adr_q.pop_front());
      end else if (spur_en && due_q.size() == 0 && !m_busy && $urandom_range(9) == 0) begin
         rv = 1'b1;
      end
      imem_rvalid = rv;
      imem_rdata  = rd;
      #1;
      exp_req = drv_rst && !m_busy && !m_have && !drv_redir;
      obs_req = imem_req;   obs_addr = imem_addr; obs_valid = instr_valid;
      obs_instr = instr;    obs_ipc = instr_pc;
      if (chk_en) begin
         check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) check("imem_addr", imem_addr, m_pc);
         check("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
         check("instr", instr, m_instr);
         check("instr_pc", instr_pc, m_ipc);
         check("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
      end
      if (imem_req === 1'b1) begin
         req_cyc.push_back(cyc);
         req_adr.push_back(imem_addr);
      end
      if (instr_valid === 1'b1) begin
         if (first_valid < 0) begin
            first_valid = cyc;
            first_op    = opcode;
         end
         if (instr_pc === watch_pc) watch_hits++;
      end
      // model update for the coming edge
      resp = m_busy && rv;
      if (!drv_rst) begin
         m_pc = 32'h0; m_busy = 0; m_stale = 0; m_have = 0; m_instr = '0; m_ipc = '0;
      end else if (drv_redir) begin
         m_pc   = drv_rpc & 32'hFFFF_FFFC;
         m_have = 0;
         if (resp) begin
            m_busy = 0; m_stale = 0;
         end else if (m_busy) begin
            m_stale = 1;
         end
      end else if (exp_req) begin
         m_busy = 1;
         lat = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
         due_q.push_back(cyc + lat);
         adr_q.push_back(m_pc);
      end else if (resp) begin
         m_busy = 0;
         if (m_stale) m_stale = 0;
         else begin
            m_have = 1; m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 32'd4;
         end
      end else if (m_have && drv_ready) begin
         m_have = 0;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect(input logic [31:0] target);
      drv_redir = 1'b1;
      drv_rpc   = target;
      step();
      drv_redir = 1'b0;
   endtask

   // Drain to an idle point where the next cycle would issue a request.
   task automatic settle();
      int n = 0;
      drv_redir = 1'b0;
      drv_ready = 1'b1;
      while ((m_busy || m_have) && n < 50) begin
         step();
         n++;
      end
      check("settle_budget", {31'b0, (m_busy || m_have)}, 32'd0);
   endtask

   task automatic clear_log();
      req_cyc.delete();
      req_adr.delete();
      first_valid = -1;
      watch_hits  = 0;
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      instr_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

      // Reset state
      drv_rst = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      check("rst_valid", {31'b0, obs_valid}, 32'd0);
      check("rst_instr", obs_instr, 32'd0);
      check("rst_ipc", obs_ipc, 32'd0);
      check("rst_req", {31'b0, obs_req}, 32'd0);

      // Basic fetch, 1-cycle memory, ready high
      drv_rst = 1'b1; mem_lat = 1; drv_ready = 1'b1;
      clear_log();
      run(9);
      check("t1_nreq", {31'b0, req_adr.size() >= 3}, 32'd1);
      check("t1_addr0", req_adr[0], 32'h0);
      check("t1_addr1", req_adr[1], 32'h4);
      check("t1_addr2", req_adr[2], 32'h8);
      check("t1_space01", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      check("t1_space12", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
      check("t1_first_valid", 32'(first_valid - req_cyc[0]), 32'd2);
      check("t1_first_op", {25'b0, first_op}, {25'b0, 7'b0010011});

      // Backpressure at 0x10
      settle();
      mem_lat = 1;
      redirect(32'h10);
      drv_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (obs_valid === 1'b1) break;
      end
      check("t2_got_valid", {31'b0, obs_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_instr", obs_instr, 32'h00A0_0023);
         check("t2_hold_ipc", obs_ipc, 32'h10);
         check("t2_hold_noreq", {31'b0, obs_req}, 32'd0);
      end
      clear_log();
      drv_ready = 1'b1;
      run(4);
      check("t2_next_addr", req_adr[0], 32'h14);

      // Redirect while a request is outstanding
      settle();
      mem_lat = 4;
      redirect(32'h20);
      clear_log();
      watch_pc = 32'h20;
      step();
      drv_redir = 1'b1; drv_rpc = 32'h101;
      step();
      drv_redir = 1'b0;
      run(3);
      mem_lat = 1;
      run(6);
      check("t3_addr0", req_adr[0], 32'h20);
      check("t3_addr1", req_adr[1], 32'h100);
      check("t3_addr2", req_adr[2], 32'h104);
      check("t3_dropped", 32'(watch_hits), 32'd0);

      // Redirect coinciding with rvalid, then redirect while holding
      settle();
      mem_lat = 1;
      redirect(32'h40);
      clear_log();
      watch_pc = 32'h40;
      step();
      drv_redir = 1'b1; drv_rpc = 32'h80;
      step();
      drv_redir = 1'b0;
      run(2);
      drv_redir = 1'b1; drv_rpc = 32'hC0; drv_ready = 1'b1;
      step();
      check("t4_held_valid", {31'b0, obs_valid}, 32'd1);
      check("t4_held_pc", obs_ipc, 32'h80);
      drv_redir = 1'b0;
      step();
      check("t4_invalidated", {31'b0, obs_valid}, 32'd0);
      run(2);
      check("t4_addr0", req_adr[0], 32'h40);
      check("t4_addr1", req_adr[1], 32'h80);
      check("t4_addr2", req_adr[2], 32'hC0);
      check("t4_no_stale", 32'(watch_hits), 32'd0);

      // PC wrap
      settle();
      mem_lat = 1;
      redirect(32'hFFFF_FFFC);
      clear_log();
      run(5);
      check("t5_addr0", req_adr[0], 32'hFFFF_FFFC);
      check("t5_wrap", req_adr[1], 32'h0);

      // Reset mid-WAIT with a pending drop; late response arrives after reset
      settle();
      mem_lat = 4;
      redirect(32'h200);
      step();
      drv_redir = 1'b1; drv_rpc = 32'h300;
      step();
      drv_redir = 1'b0;
      drv_rst = 1'b0;
      run(2);
      check("t6_req_in_rst", {31'b0, obs_req}, 32'd0);
      check("t6_valid_in_rst", {31'b0, obs_valid}, 32'd0);
      drv_rst = 1'b1;
      mem_lat = 1;
      clear_log();
      step();
      check("t6_late_rvalid", {31'b0, imem_rvalid}, 32'd1);
      check("t6_req", {31'b0, obs_req}, 32'd1);
      check("t6_addr", obs_addr, 32'h0);
      check("t6_valid", {31'b0, obs_valid}, 32'd0);
      run(4);
      check("t6_addr1", req_adr[1], 32'h4);

      // Randomized traffic
      settle();
      mem_lat = 0;
      spur_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         drv_redir = ($urandom_range(15) == 0);
         drv_rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : $urandom;
         drv_ready = ($urandom_range(3) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
